// File: rtl/token_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | token_stage_fifo : DEPTH-slot token buffer with send/ack handshake on both  |
// | sides, lopen stall gate, occupancy count and CEX write strobe. Rev 1.0      |
// +----------------------------------------------------------------------------+
module token_stage_fifo #(
   parameter int NODE_W = 16,
   parameter int GEN_W  = 12,
   parameter int OPR_W  = 32,
   parameter int WEN_W  = 2,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lopen,
   input  logic              send_i,
   output logic              ack_o,
   input  logic [NODE_W-1:0] node_i,
   input  logic [GEN_W-1:0]  gen_i,
   input  logic [OPR_W-1:0]  opr0_i,
   input  logic [OPR_W-1:0]  opr1_i,
   input  logic [WEN_W-1:0]  mem_wen_i,
   output logic              send_o,
   input  logic              ack_i,
   output logic [NODE_W-1:0] node_o,
   output logic [GEN_W-1:0]  gen_o,
   output logic [OPR_W-1:0]  opr0_o,
   output logic [OPR_W-1:0]  opr1_o,
   output logic [WEN_W-1:0]  mem_wen_o,
   output logic              w_en_cex_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int TOK_W = NODE_W + GEN_W + 2 * OPR_W + WEN_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [TOK_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic [TOK_W-1:0] head;

   assign not_empty = (count != '0);
   // ack is also forced low by rst so upstream never sees a stale accept.
   assign ack_o  = lopen & ~rst & (count != FULL_CNT);
   assign send_o = lopen & not_empty;
   assign push   = send_i & ack_o;
   assign pop    = send_o & ack_i;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {node_i, gen_i, opr0_i, opr1_i, mem_wen_i};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head stays visible while lopen is low; zero only when truly empty.
   assign head = not_empty ? mem[rd_ptr] : '0;
   assign {node_o, gen_o, opr0_o, opr1_o, mem_wen_o} = head;

   assign w_en_cex_o = send_o & (|mem_wen_o);
   assign count_o    = count;

endmodule
`default_nettype wire

// File: tb/tb_token_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_token_stage_fifo : randomized + directed scoreboard bench for           |
// | token_stage_fifo against a queue-based reference model. Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_token_stage_fifo;

   localparam int NODE_W = 16;
   localparam int GEN_W  = 12;
   localparam int OPR_W  = 32;
   localparam int WEN_W  = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [NODE_W-1:0] node;
      logic [GEN_W-1:0]  gen;
      logic [OPR_W-1:0]  opr0;
      logic [OPR_W-1:0]  opr1;
      logic [WEN_W-1:0]  wen;
   } tok_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              lopen = 1'b0;
   logic              send_i = 1'b0;
   logic              ack_o;
   tok_t              tin = '0;
   logic              send_o;
   logic              ack_i = 1'b0;
   logic [NODE_W-1:0] node_o;
   logic [GEN_W-1:0]  gen_o;
   logic [OPR_W-1:0]  opr0_o;
   logic [OPR_W-1:0]  opr1_o;
   logic [WEN_W-1:0]  mem_wen_o;
   logic              w_en_cex_o;
   logic [CNT_W-1:0]  count_o;

   int total = 0;
   int bad   = 0;
   tok_t exp_q[$];

   always #5 clk = ~clk;

   token_stage_fifo #(
      .NODE_W(NODE_W), .GEN_W(GEN_W), .OPR_W(OPR_W),
      .WEN_W(WEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .lopen(lopen),
      .send_i(send_i), .ack_o(ack_o),
      .node_i(tin.node), .gen_i(tin.gen), .opr0_i(tin.opr0), .opr1_i(tin.opr1),
      .mem_wen_i(tin.wen),
      .send_o(send_o), .ack_i(ack_i),
      .node_o(node_o), .gen_o(gen_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
      .mem_wen_o(mem_wen_o), .w_en_cex_o(w_en_cex_o), .count_o(count_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare DUT against the queue model, then apply this cycle's
   // accept/emit decisions (inputs are stable from here to the next edge).
   always @(negedge clk) begin
      tok_t head;
      logic e_ack, e_send, do_push, do_pop;
      if (rst) begin
         exp_q.delete();
         chk("rst_ack", ack_o, 0);
         chk("rst_send", send_o, 0);
         chk("rst_count", count_o, 0);
         chk("rst_data", {node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, 0);
         chk("rst_wen", w_en_cex_o, 0);
      end else begin
         head   = (exp_q.size() > 0) ? exp_q[0] : '0;
         e_ack  = lopen && (exp_q.size() < DEPTH);
         e_send = lopen && (exp_q.size() > 0);
         chk("ack_o", ack_o, e_ack);
         chk("send_o", send_o, e_send);
         chk("count_o", count_o, exp_q.size());
         chk("head_data", {node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, head);
         chk("w_en_cex", w_en_cex_o, e_send && (head.wen != 0));
         do_push = send_i && e_ack;
         do_pop  = e_send && ack_i;
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(tin);
      end
   end

   task automatic step(input logic s, input logic a, input logic l, input tok_t t);
      @(posedge clk);
      #1;
      send_i = s;
      ack_i  = a;
      lopen  = l;
      tin    = t;
   endtask

   function automatic tok_t mk(input int n);
      tok_t t;
      t.node = NODE_W'(n);
      t.gen  = GEN_W'($urandom);
      t.opr0 = $urandom;
      t.opr1 = $urandom;
      t.wen  = WEN_W'($urandom_range(1, 3));
      return t;
   endfunction

   initial begin
      tok_t t;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single token, known values
      t = '{node: 16'h1234, gen: 12'h0AB, opr0: 32'hDEADBEEF, opr1: 32'h1, wen: 2'b10};
      step(1, 0, 1, t);
      step(0, 0, 1, '0);
      #3 chk("single_node", node_o, 16'h1234);
      chk("single_wen", w_en_cex_o, 1);
      step(0, 1, 1, '0);
      step(0, 0, 1, '0);
      #3 chk("single_drained", count_o, 0);

      // fill past full: node 5 refused
      for (int i = 1; i <= 5; i++) step(1, 0, 1, mk(i));
      step(0, 0, 1, '0);
      #3 chk("full_count", count_o, 4);
      chk("full_ack", ack_o, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, '0);

      // streaming with pointer wrap
      for (int i = 0; i < 20; i++) step(1, 1, 1, mk(100 + i));
      step(0, 1, 1, '0);
      step(0, 0, 1, '0);

      // full with simultaneous ack: pop only, then next push accepted
      for (int i = 0; i < 4; i++) step(1, 0, 1, mk(200 + i));
      step(1, 1, 1, mk(210));
      step(1, 0, 1, mk(211));
      step(0, 0, 1, '0);
      #3 chk("full_ack_refill", count_o, 4);
      for (int i = 0; i < 4; i++) step(0, 1, 1, '0);

      // lopen stall holding nodes 7,8; zero write-enable head
      t = mk(7); t.wen = 2'b00;
      step(1, 0, 1, t);
      step(1, 0, 1, mk(8));
      for (int i = 0; i < 3; i++) step(1, 1, 0, mk(9));
      #3 chk("stall_node", node_o, 7);
      step(0, 1, 1, '0);
      step(0, 1, 1, '0);
      step(0, 0, 1, '0);
      t = mk(3); t.wen = 2'b01;
      step(1, 0, 1, t);
      step(0, 0, 0, '0);
      #3 chk("closed_wen", w_en_cex_o, 0);
      step(0, 1, 1, '0);

      // asynchronous reset between edges with three tokens held
      for (int i = 0; i < 3; i++) step(1, 0, 1, mk(300 + i));
      step(0, 0, 1, '0);
      #2 rst = 1'b1;
      #1 chk("arst_send", send_o, 0);
      chk("arst_count", count_o, 0);
      chk("arst_node", node_o, 0);
      step(0, 0, 1, '0);
      step(0, 0, 1, '0);
      rst = 1'b0;
      step(0, 1, 1, '0);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), mk(1000 + i));
      for (int i = 0; i < 6; i++) step(0, 1, 1, '0);
      step(0, 0, 1, '0);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
